// File: rtl/dm_pkg.sv
// Shared codes and types for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_pkg;

  // Store-width codes forwarded to the DM
  localparam logic [1:0] SAVE_WORD = 2'd0;
  localparam logic [1:0] SAVE_HALF = 2'd1;
  localparam logic [1:0] SAVE_BYTE = 2'd2;

  // Read-width/sign codes forwarded to the DM
  localparam logic [2:0] READ_WORD   = 3'b000;
  localparam logic [2:0] READ_HALF_U = 3'b001;
  localparam logic [2:0] READ_HALF_S = 3'b010;
  localparam logic [2:0] READ_BYTE_U = 3'b011;
  localparam logic [2:0] READ_BYTE_S = 3'b100;

  // Grant select seen by the field mux: {c_gnt, l_gnt}
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LDR  = 2'b01;
  localparam logic [1:0] SEL_CPU  = 2'b10;

  // Arbiter states
  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_LOAD  = 2'd1,
    S_YIELD = 2'd2
  } arb_state_t;

  // One requester's access fields, bundled for the mux
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  savesel;
    logic [2:0]  readsel;
  } dm_req_t;

endpackage

// File: rtl/dm_req_mux.sv
// Steers the granted requester's fields onto the DM port and forms the write enable.
// Latency: purely combinational.
// Backpressure: none; with no grant the CPU fields are shown and the write enable is held low.
module dm_req_mux
  import dm_pkg::*;
(
  input  logic        c_gnt,
  input  logic        l_gnt,
  input  dm_req_t     c_fld,
  input  dm_req_t     l_fld,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [1:0]  dm_savesel,
  output logic [2:0]  dm_readsel,
  output logic        dm_en
);

  dm_req_t sel_fld;

  // Pick the owning port; a write only happens for a granted store
  always_comb begin
    sel_fld = c_fld;
    dm_en   = 1'b0;
    case ({c_gnt, l_gnt})
      SEL_LDR: begin
        sel_fld = l_fld;
        dm_en   = l_fld.we;
      end
      SEL_CPU: begin
        sel_fld = c_fld;
        dm_en   = c_fld.we;
      end
      default: begin
        sel_fld = c_fld;
        dm_en   = 1'b0;
      end
    endcase
  end

  assign dm_addr    = sel_fld.addr;
  assign dm_wdata   = sel_fld.wdata;
  assign dm_savesel = sel_fld.savesel;
  assign dm_readsel = sel_fld.readsel;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-port DM between the CPU M-stage (priority) and a loader with bounded wait and bounded locked bursts.
// Latency: grants and DM drive are same-cycle; loader read data returns one cycle after l_gnt.
// Backpressure: CPU is stalled (c_stall) while locked out; loader simply holds its request until l_gnt.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int WAIT_MAX  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [1:0]  c_savesel,
  input  logic [2:0]  c_readsel,
  output logic        c_stall,
  output logic [31:0] c_rdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic        l_lock,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  input  logic [1:0]  l_savesel,
  input  logic [2:0]  l_readsel,
  output logic        l_gnt,
  output logic [31:0] l_rdata,
  output logic        l_rvalid,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [1:0]  dm_savesel,
  output logic [2:0]  dm_readsel,
  output logic        dm_en,
  input  logic [31:0] dm_dout
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM  = WW'(WAIT_MAX);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  arb_state_t    state, state_nxt;
  logic [WW-1:0] wait_cnt, wait_nxt;
  logic [BW-1:0] beat_cnt, beat_nxt, beat_inc;
  logic          c_gnt, l_gnt_i;
  dm_req_t       c_fld, l_fld;

  assign c_fld = '{we: c_we, addr: c_addr, wdata: c_wdata, savesel: c_savesel, readsel: c_readsel};
  assign l_fld = '{we: l_we, addr: l_addr, wdata: l_wdata, savesel: l_savesel, readsel: l_readsel};

  // Grant decision and next-state/counter update for the arbitration FSM
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    beat_nxt  = beat_cnt;
    beat_inc  = beat_cnt + 1'b1;
    c_gnt     = 1'b0;
    l_gnt_i   = 1'b0;

    case (state)
      S_CPU: begin
        // Loader wins when alone, or when it has lost WAIT_MAX contended cycles in a row
        if (l_req && (!c_req || (wait_cnt == WAIT_LIM))) begin
          l_gnt_i = 1'b1;
          if (l_lock) begin
            state_nxt = S_LOAD;
            beat_nxt  = BW'(1);
          end
        end else if (c_req) begin
          c_gnt = 1'b1;
          if (l_req) wait_nxt = wait_cnt + 1'b1;
        end
      end

      S_LOAD: begin
        // CPU is locked out; the burst ends on a dropped request, an unlocked beat, or the length cap
        if (!l_req) begin
          state_nxt = S_CPU;
          beat_nxt  = '0;
        end else begin
          l_gnt_i  = 1'b1;
          beat_nxt = beat_inc;
          if (!l_lock) begin
            state_nxt = S_CPU;
            beat_nxt  = '0;
          end else if (beat_inc == BURST_LIM) begin
            state_nxt = S_YIELD;
          end
        end
      end

      S_YIELD: begin
        // One guaranteed CPU slot after a maximal burst
        c_gnt     = c_req;
        state_nxt = S_CPU;
        wait_nxt  = '0;
        beat_nxt  = '0;
      end

      default: begin
        state_nxt = S_CPU;
        wait_nxt  = '0;
        beat_nxt  = '0;
      end
    endcase

    // The wait window restarts whenever the loader gets in or stops asking
    if (l_gnt_i || !l_req) wait_nxt = '0;

    // No access of any kind is allowed during a reset cycle
    if (!reset) begin
      c_gnt   = 1'b0;
      l_gnt_i = 1'b0;
    end
  end

  // State, counters and the loader read-data return register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
      l_rdata  <= '0;
      l_rvalid <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
      l_rvalid <= l_gnt_i & ~l_we;
      if (l_gnt_i && !l_we) l_rdata <= dm_dout;
    end
  end

  assign l_gnt   = l_gnt_i;
  assign c_stall = c_req & ~c_gnt & reset;
  assign c_rdata = dm_dout;

  dm_req_mux u_mux (
    .c_gnt      (c_gnt),
    .l_gnt      (l_gnt_i),
    .c_fld      (c_fld),
    .l_fld      (l_fld),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_savesel (dm_savesel),
    .dm_readsel (dm_readsel),
    .dm_en      (dm_en)
  );

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// Latency: checks comb outputs 1ns after inputs change at negedge; registered outputs the next cycle.
// Backpressure: requesters hold fields until the expected grant.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int WAIT_MAX  = 4;
  localparam int BURST_MAX = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [1:0]  c_savesel;
  logic [2:0]  c_readsel;
  logic        c_stall;
  logic [31:0] c_rdata;
  logic        l_req, l_we, l_lock;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_savesel;
  logic [2:0]  l_readsel;
  logic        l_gnt;
  logic [31:0] l_rdata;
  logic        l_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_dout;
  logic [1:0]  dm_savesel;
  logic [2:0]  dm_readsel;
  logic        dm_en;

  int tests_run = 0;
  int fails     = 0;

  // Data memory seen by the DUT, and the bench's own expectation of its contents
  logic [31:0] mem    [0:63] = '{default: 32'h0};
  logic [31:0] shadow [0:63] = '{default: 32'h0};

  function automatic logic [31:0] rd_fmt(input logic [31:0] w, input logic [1:0] off, input logic [2:0] rs);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? w[31:16] : w[15:0];
    b = w[{off, 3'b000} +: 8];
    case (rs)
      READ_HALF_U: return {16'h0, h};
      READ_HALF_S: return {{16{h[15]}}, h};
      READ_BYTE_U: return {24'h0, b};
      READ_BYTE_S: return {{24{b[7]}}, b};
      default:     return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [1:0] off, input logic [1:0] ss);
    logic [31:0] r;
    r = old;
    case (ss)
      SAVE_WORD: r = wd;
      SAVE_HALF: if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      SAVE_BYTE: r[{off, 3'b000} +: 8] = wd[7:0];
      default:   r = old;
    endcase
    return r;
  endfunction

  assign dm_dout = rd_fmt(mem[dm_addr[7:2]], dm_addr[1:0], dm_readsel);
  always @(posedge clk) if (dm_en) mem[dm_addr[7:2]] <= merge(mem[dm_addr[7:2]], dm_wdata, dm_addr[1:0], dm_savesel);

  dm_arbiter #(.WAIT_MAX(WAIT_MAX), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_savesel(c_savesel), .c_readsel(c_readsel), .c_stall(c_stall), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_savesel(l_savesel), .l_readsel(l_readsel), .l_gnt(l_gnt), .l_rdata(l_rdata), .l_rvalid(l_rvalid),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_savesel(dm_savesel), .dm_readsel(dm_readsel),
    .dm_en(dm_en), .dm_dout(dm_dout)
  );

  task automatic cpu_drv(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] ss, input logic [2:0] rs);
    c_req = req; c_we = we; c_addr = addr; c_wdata = wd; c_savesel = ss; c_readsel = rs;
  endtask

  task automatic ldr_drv(input logic req, input logic we, input logic lock, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] ss, input logic [2:0] rs);
    l_req = req; l_we = we; l_lock = lock; l_addr = addr; l_wdata = wd; l_savesel = ss; l_readsel = rs;
  endtask

  task automatic idle();
    cpu_drv(1'b0, 1'b0, 32'h0, 32'h0, SAVE_WORD, READ_WORD);
    ldr_drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SAVE_WORD, READ_WORD);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_drv(1'b1, 1'b1, 32'h0, 32'hDEADBEEF, SAVE_WORD, READ_WORD);
    ldr_drv(1'b1, 1'b1, 1'b1, 32'h4, 32'h12345678, SAVE_WORD, READ_WORD);
    #1;
    tests_run++; if (c_stall !== 1'b0) begin fails++; $display("FAIL rst_c_stall got %b want 0", c_stall); end
    tests_run++; if (l_gnt !== 1'b0) begin fails++; $display("FAIL rst_l_gnt got %b want 0", l_gnt); end
    tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL rst_dm_en got %b want 0", dm_en); end
    @(negedge clk); #1;
    tests_run++; if (l_rvalid !== 1'b0) begin fails++; $display("FAIL rst_l_rvalid got %b want 0", l_rvalid); end
    tests_run++; if (l_rdata !== 32'h0) begin fails++; $display("FAIL rst_l_rdata got %h want 0", l_rdata); end
    @(negedge clk); reset = 1'b1; idle(); #1;
    tests_run++; if (mem[0] !== 32'h0) begin fails++; $display("FAIL rst_no_write got %h want 0", mem[0]); end
  endtask

  task automatic test_cpu_only();
    @(negedge clk); idle(); cpu_drv(1'b1, 1'b1, 32'h0, 32'h87654321, SAVE_WORD, READ_WORD); #1;
    tests_run++; if (c_stall !== 1'b0) begin fails++; $display("FAIL cpu_sw_stall got %b want 0", c_stall); end
    tests_run++; if (dm_en !== 1'b1) begin fails++; $display("FAIL cpu_sw_dm_en got %b want 1", dm_en); end
    @(negedge clk); cpu_drv(1'b1, 1'b0, 32'h0, 32'h0, SAVE_WORD, READ_WORD); #1;
    tests_run++; if (c_stall !== 1'b0) begin fails++; $display("FAIL cpu_lw_stall got %b want 0", c_stall); end
    tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL cpu_lw_dm_en got %b want 0", dm_en); end
    tests_run++; if (c_rdata !== 32'h87654321) begin fails++; $display("FAIL cpu_lw_rdata got %h want 87654321", c_rdata); end
    @(negedge clk); idle(); #1;
    tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL cpu_idle_dm_en got %b want 0", dm_en); end
  endtask

  task automatic test_loader_only();
    @(negedge clk); idle(); ldr_drv(1'b1, 1'b0, 1'b0, 32'h3, 32'h0, SAVE_WORD, READ_BYTE_U); #1;
    tests_run++; if (l_gnt !== 1'b1) begin fails++; $display("FAIL ldr_lbu_gnt got %b want 1", l_gnt); end
    tests_run++; if (dm_addr !== 32'h3) begin fails++; $display("FAIL ldr_lbu_addr got %h want 3", dm_addr); end
    tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL ldr_lbu_dm_en got %b want 0", dm_en); end
    @(negedge clk); ldr_drv(1'b1, 1'b0, 1'b0, 32'h3, 32'h0, SAVE_WORD, READ_BYTE_S); #1;
    tests_run++; if (l_gnt !== 1'b1) begin fails++; $display("FAIL ldr_lb_gnt got %b want 1", l_gnt); end
    tests_run++; if (l_rvalid !== 1'b1) begin fails++; $display("FAIL ldr_lbu_rvalid got %b want 1", l_rvalid); end
    tests_run++; if (l_rdata !== 32'h00000087) begin fails++; $display("FAIL ldr_lbu_rdata got %h want 00000087", l_rdata); end
    @(negedge clk); idle(); #1;
    tests_run++; if (l_rvalid !== 1'b1) begin fails++; $display("FAIL ldr_lb_rvalid got %b want 1", l_rvalid); end
    tests_run++; if (l_rdata !== 32'hFFFFFF87) begin fails++; $display("FAIL ldr_lb_rdata got %h want ffffff87", l_rdata); end
    @(negedge clk); #1;
    tests_run++; if (l_rvalid !== 1'b0) begin fails++; $display("FAIL ldr_rvalid_pulse got %b want 0", l_rvalid); end
  endtask

  task automatic test_contention();
    logic exp_l;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cpu_drv(1'b1, 1'b0, 32'h10, 32'h0, SAVE_WORD, READ_WORD);
      ldr_drv(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, SAVE_WORD, READ_WORD);
      #1;
      exp_l = ((i % (WAIT_MAX + 1)) == WAIT_MAX);
      tests_run++; if (l_gnt !== exp_l) begin fails++; $display("FAIL cont_l_gnt cyc %0d got %b want %b", i, l_gnt, exp_l); end
      tests_run++; if (c_stall !== exp_l) begin fails++; $display("FAIL cont_c_stall cyc %0d got %b want %b", i, c_stall, exp_l); end
      tests_run++; if (dm_addr !== (exp_l ? 32'h20 : 32'h10)) begin fails++; $display("FAIL cont_dm_addr cyc %0d got %h", i, dm_addr); end
    end
    @(negedge clk); idle(); #1;
  endtask

  task automatic test_locked_burst();
    logic exp_l;
    int beat;
    beat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu_drv(1'b1, 1'b0, 32'h80, 32'h0, SAVE_WORD, READ_WORD);
      if (beat < 10) ldr_drv(1'b1, 1'b1, (beat < 9), 32'(4 * beat), 32'hA0000000 + 32'(beat), SAVE_WORD, READ_WORD);
      else           ldr_drv(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SAVE_WORD, READ_WORD);
      #1;
      // 4 CPU wins, 8 locked beats, yield, 4 CPU wins, final 2 beats
      exp_l = (i >= WAIT_MAX && i < WAIT_MAX + BURST_MAX) || (i == 2 * WAIT_MAX + BURST_MAX + 1) || (i == 2 * WAIT_MAX + BURST_MAX + 2);
      tests_run++; if (l_gnt !== exp_l) begin fails++; $display("FAIL burst_l_gnt cyc %0d got %b want %b", i, l_gnt, exp_l); end
      tests_run++; if (c_stall !== exp_l) begin fails++; $display("FAIL burst_c_stall cyc %0d got %b want %b", i, c_stall, exp_l); end
      if (l_gnt) beat++;
    end
    tests_run++; if (beat !== 10) begin fails++; $display("FAIL burst_beats got %0d want 10", beat); end
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk); idle();
      if (i < 10) ldr_drv(1'b1, 1'b0, 1'b0, 32'(4 * i), 32'h0, SAVE_WORD, READ_WORD);
      #1;
      if (i < 10) begin
        tests_run++; if (l_gnt !== 1'b1) begin fails++; $display("FAIL burst_rb_gnt word %0d got %b want 1", i, l_gnt); end
      end
      if (i > 0) begin
        tests_run++; if (l_rvalid !== 1'b1 || l_rdata !== 32'hA0000000 + 32'(i - 1))
          begin fails++; $display("FAIL burst_rb_data word %0d got %b/%h want 1/%h", i - 1, l_rvalid, l_rdata, 32'hA0000000 + 32'(i - 1)); end
      end
    end
    @(negedge clk); idle(); #1;
  endtask

  task automatic test_reset_burst();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle();
      if (i < 3) begin
        ldr_drv(1'b1, 1'b1, 1'b1, 32'(4 * i), 32'hB0000000 + 32'(i), SAVE_WORD, READ_WORD); #1;
        tests_run++; if (l_gnt !== 1'b1) begin fails++; $display("FAIL rstb_beat_gnt beat %0d got %b want 1", i, l_gnt); end
      end else begin
        reset = 1'b0;
        cpu_drv(1'b1, 1'b0, 32'h80, 32'h0, SAVE_WORD, READ_WORD);
        ldr_drv(1'b1, 1'b1, 1'b1, 32'hC, 32'hB0000003, SAVE_WORD, READ_WORD); #1;
        tests_run++; if (l_gnt !== 1'b0) begin fails++; $display("FAIL rstb_l_gnt got %b want 0", l_gnt); end
        tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL rstb_dm_en got %b want 0", dm_en); end
        tests_run++; if (c_stall !== 1'b0) begin fails++; $display("FAIL rstb_c_stall got %b want 0", c_stall); end
      end
    end
    @(negedge clk); reset = 1'b1; #1;
    tests_run++; if (l_rvalid !== 1'b0) begin fails++; $display("FAIL rstb_l_rvalid got %b want 0", l_rvalid); end
    tests_run++; if (l_rdata !== 32'h0) begin fails++; $display("FAIL rstb_l_rdata got %h want 0", l_rdata); end
    // Back in S_CPU with a fresh wait window, so the CPU wins the contention
    tests_run++; if (l_gnt !== 1'b0 || c_stall !== 1'b0) begin fails++; $display("FAIL rstb_state got l_gnt=%b c_stall=%b want 0/0", l_gnt, c_stall); end
    @(negedge clk); idle(); #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cpu_drv(1'b1, 1'b0, 32'(4 * i), 32'h0, SAVE_WORD, READ_WORD); #1;
      tests_run++; if (c_rdata !== ((i < 3) ? 32'hB0000000 + 32'(i) : 32'hA0000003))
        begin fails++; $display("FAIL rstb_readback word %0d got %h", i, c_rdata); end
    end
    @(negedge clk); idle(); #1;
  endtask

  task automatic test_drop_in_load();
    @(negedge clk); idle(); ldr_drv(1'b1, 1'b1, 1'b1, 32'hA0, 32'hCAFEF00D, SAVE_WORD, READ_WORD); #1;
    tests_run++; if (l_gnt !== 1'b1) begin fails++; $display("FAIL drop_first_gnt got %b want 1", l_gnt); end
    @(negedge clk);
    ldr_drv(1'b0, 1'b1, 1'b1, 32'hA4, 32'h0, SAVE_WORD, READ_WORD);
    cpu_drv(1'b1, 1'b0, 32'hA0, 32'h0, SAVE_WORD, READ_WORD); #1;
    tests_run++; if (l_gnt !== 1'b0) begin fails++; $display("FAIL drop_l_gnt got %b want 0", l_gnt); end
    tests_run++; if (c_stall !== 1'b1) begin fails++; $display("FAIL drop_c_stall got %b want 1", c_stall); end
    tests_run++; if (dm_en !== 1'b0) begin fails++; $display("FAIL drop_dm_en got %b want 0", dm_en); end
    @(negedge clk); #1;
    tests_run++; if (c_stall !== 1'b0) begin fails++; $display("FAIL drop_cpu_next got %b want 0", c_stall); end
    tests_run++; if (c_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL drop_cpu_rdata got %h want cafef00d", c_rdata); end
    @(negedge clk); idle(); #1;
  endtask

  task automatic pick(output logic we, output logic [31:0] addr, output logic [31:0] wd,
                      output logic [1:0] ss, output logic [2:0] rs);
    logic [1:0] off;
    logic [3:0] idx;
    we  = 1'($urandom_range(0, 1));
    wd  = $urandom;
    idx = 4'($urandom_range(0, 15));
    ss  = 2'($urandom_range(0, 2));
    rs  = 3'($urandom_range(0, 4));
    if (we) off = (ss == SAVE_WORD) ? 2'd0 : (ss == SAVE_HALF) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
    else    off = (rs == READ_WORD) ? 2'd0 : (rs <= READ_HALF_S) ? {1'($urandom_range(0, 1)), 1'b0} : 2'($urandom_range(0, 3));
    addr = {24'h0, 2'b01, idx, off};
  endtask

  task automatic test_random();
    int contended, burst_len;
    bit cpu_turn, cp, lp, rst, eg_c, eg_l, exp_rv;
    logic [31:0] exp_rd, caddr, cwd, laddr, lwd;
    logic cwe, lwe, lk;
    logic [1:0] css, lss;
    logic [2:0] crs, lrs;
    contended = 0; burst_len = 0; cpu_turn = 0; cp = 0; lp = 0; exp_rv = 0; exp_rd = 32'h0;
    cwe = 0; lwe = 0; lk = 0; caddr = 0; cwd = 0; laddr = 0; lwd = 0; css = 0; lss = 0; crs = 0; lrs = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (!cp && $urandom_range(0, 99) < 60) begin cp = 1; pick(cwe, caddr, cwd, css, crs); end
      if (!lp && $urandom_range(0, 99) < ((burst_len > 0) ? 90 : 50)) begin
        lp = 1; pick(lwe, laddr, lwd, lss, lrs); lk = ($urandom_range(0, 99) < 75);
      end
      rst = ($urandom_range(0, 99) < 2);
      reset = !rst;
      cpu_drv(cp, cwe, caddr, cwd, css, crs);
      ldr_drv(lp, lwe, lk, laddr, lwd, lss, lrs);
      // Who should own the DM this cycle
      eg_c = 0; eg_l = 0;
      if (!rst) begin
        if (cpu_turn)                                     eg_c = cp;
        else if (burst_len > 0)                           eg_l = lp;
        else if (lp && (!cp || contended == WAIT_MAX))    eg_l = 1;
        else                                              eg_c = cp;
      end
      #1;
      tests_run++; if (l_rvalid !== exp_rv) begin fails++; $display("FAIL rnd_l_rvalid cyc %0d got %b want %b", n, l_rvalid, exp_rv); end
      tests_run++; if (l_rdata !== exp_rd) begin fails++; $display("FAIL rnd_l_rdata cyc %0d got %h want %h", n, l_rdata, exp_rd); end
      tests_run++; if (l_gnt !== eg_l) begin fails++; $display("FAIL rnd_l_gnt cyc %0d got %b want %b", n, l_gnt, eg_l); end
      tests_run++; if (c_stall !== (cp && !eg_c && !rst)) begin fails++; $display("FAIL rnd_c_stall cyc %0d got %b want %b", n, c_stall, cp && !eg_c && !rst); end
      tests_run++; if (dm_en !== ((eg_c && cwe) || (eg_l && lwe))) begin fails++; $display("FAIL rnd_dm_en cyc %0d got %b", n, dm_en); end
      if (eg_c || eg_l) begin
        tests_run++; if (dm_addr !== (eg_c ? caddr : laddr)) begin fails++; $display("FAIL rnd_dm_addr cyc %0d got %h want %h", n, dm_addr, eg_c ? caddr : laddr); end
      end
      if (eg_c && !cwe) begin
        tests_run++; if (c_rdata !== rd_fmt(shadow[caddr[7:2]], caddr[1:0], crs))
          begin fails++; $display("FAIL rnd_c_rdata cyc %0d got %h want %h", n, c_rdata, rd_fmt(shadow[caddr[7:2]], caddr[1:0], crs)); end
      end
      // Advance the model across the clock edge
      if (rst) begin
        contended = 0; burst_len = 0; cpu_turn = 0; exp_rv = 0; exp_rd = 32'h0;
      end else begin
        exp_rv = eg_l && !lwe;
        if (exp_rv) exp_rd = rd_fmt(shadow[laddr[7:2]], laddr[1:0], lrs);
        if (eg_c && cwe) shadow[caddr[7:2]] = merge(shadow[caddr[7:2]], cwd, caddr[1:0], css);
        if (eg_l && lwe) shadow[laddr[7:2]] = merge(shadow[laddr[7:2]], lwd, laddr[1:0], lss);
        if (cpu_turn) begin
          cpu_turn = 0; contended = 0; burst_len = 0;
        end else if (burst_len > 0) begin
          contended = 0;
          if (eg_l && lk) begin
            burst_len++;
            if (burst_len == BURST_MAX) begin burst_len = 0; cpu_turn = 1; end
          end else begin
            burst_len = 0;
          end
        end else if (eg_l) begin
          contended = 0; burst_len = lk ? 1 : 0;
        end else if (lp && cp) begin
          contended++;
        end else begin
          contended = 0;
        end
      end
      if (eg_c) cp = 0;
      if (eg_l) lp = 0;
    end
    @(negedge clk); reset = 1'b1; idle(); #1;
  endtask

  initial begin
    test_reset();
    test_cpu_only();
    test_loader_only();
    test_contention();
    test_locked_burst();
    test_reset_burst();
    test_drop_in_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
